sequence_player: RTL

Plays the stored colour sequence back to the player on the four colour LEDs, one colour at a time. It sits between the game controller and the sequence memory. The controller pulses `play_start` with the current sequence length. The block fetches each colour from memory, lights the matching LED for a speed-dependent time, blanks it for a fixed gap, and pulses `done` when the last colour has been shown. It drives the same LEDs the player watches before entering button presses, so it is the transmitting end of the colour-button exchange.

---
 rtl/sequence_player.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sequence_player.sv
// Plays a stored colour sequence on four LEDs: fetch, latch, light for a
// speed-dependent time, blank for a fixed gap, then pulse done.
module sequence_player #(
    parameter int COLOR_CODEFY_W = 2,
    parameter int ADDR_WIDTH     = 5,
    parameter int ON_CYCLES_SLOW = 8,
    parameter int ON_CYCLES_FAST = 4,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      play_start,
    input  logic [ADDR_WIDTH:0]       seq_len,
    input  logic                      speed_button,
    input  logic                      abort,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [COLOR_CODEFY_W-1:0] mem_data,
    output logic                      led_green,
    output logic                      led_red,
    output logic                      led_blue,
    output logic                      led_yellow,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_LEN = 2 ** ADDR_WIDTH;
    localparam int CNT_MAX_A = (ON_CYCLES_SLOW > ON_CYCLES_FAST) ? ON_CYCLES_SLOW : ON_CYCLES_FAST;
    localparam int CNT_MAX = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    ON_SLOW_LD = CNT_W'(ON_CYCLES_SLOW - 1);
    localparam logic [CNT_W-1:0]    ON_FAST_LD = CNT_W'(ON_CYCLES_FAST - 1);
    localparam logic [CNT_W-1:0]    GAP_LD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] LEN_CAP    = (ADDR_WIDTH + 1)'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ON,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                    r_state;
    logic [ADDR_WIDTH:0]       r_len;
    logic [ADDR_WIDTH:0]       r_idx;
    logic                      r_fast;
    logic [COLOR_CODEFY_W-1:0] r_colour;
    logic [CNT_W-1:0]          r_cnt;
    logic [3:0]                r_led;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_rd_en;
    logic [ADDR_WIDTH-1:0]     r_addr;

    logic [ADDR_WIDTH:0]       w_idx_next;
    logic                      w_last;

    assign w_idx_next = r_idx + 1'b1;
    assign w_last     = (w_idx_next == r_len);

    // One-hot LED vector ordered {yellow, blue, red, green}.
    function automatic logic [3:0] f_decode(input logic [COLOR_CODEFY_W-1:0] c);
        f_decode = '0;
        if (c == COLOR_CODEFY_W'(0))      f_decode[0] = 1'b1;
        else if (c == COLOR_CODEFY_W'(1)) f_decode[1] = 1'b1;
        else if (c == COLOR_CODEFY_W'(2)) f_decode[2] = 1'b1;
        else if (c == COLOR_CODEFY_W'(3)) f_decode[3] = 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_idx    <= '0;
            r_fast   <= 1'b0;
            r_colour <= '0;
            r_cnt    <= '0;
            r_led    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (play_start) begin
                        r_len  <= (seq_len > LEN_CAP) ? LEN_CAP : seq_len;
                        r_fast <= speed_button;
                        r_idx  <= '0;
                        // Zero length skips straight to the done pulse; busy never rises.
                        if (seq_len == '0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_busy  <= 1'b1;
                            r_rd_en <= 1'b1;
                            r_addr  <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_colour <= mem_data;
                    r_led    <= f_decode(mem_data);
                    r_cnt    <= r_fast ? ON_FAST_LD : ON_SLOW_LD;
                    r_state  <= S_ON;
                end
                S_ON: begin
                    if (r_cnt == '0) begin
                        r_led   <= '0;
                        r_cnt   <= GAP_LD;
                        r_state <= S_GAP;
                    end else begin
                        r_led <= f_decode(r_colour);
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_last) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= w_idx_next;
                        r_addr  <= w_idx_next[ADDR_WIDTH-1:0];
                        r_rd_en <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_addr;
    assign led_green  = r_led[0];
    assign led_red    = r_led[1];
    assign led_blue   = r_led[2];
    assign led_yellow = r_led[3];
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
